// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared constants, FSM state type and address decode for the LC-3 memory controller.
package lc3_mem_pkg;

   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;
   localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

   localparam logic [15:0] MCR_RESET = 16'h8000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } mem_state_e;

   // True when the address selects one of the memory-mapped device registers.
   function automatic logic is_mmio(input logic [15:0] addr);
      return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) || (addr == DSR_ADDR) ||
             (addr == DDR_ADDR)  || (addr == MCR_ADDR);
   endfunction

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// CPU-side load/store request bus (MAR/MDR side of the datapath).
interface lc3_mem_ctrl_if;

   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_done;
   logic [15:0] mem_rdata;
   logic        mem_err;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_done, mem_rdata, mem_err
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_done, mem_rdata, mem_err
   );

endinterface

// File: rtl/lc3_mem_ctrl_mmio_regs.sv
// Memory-mapped device registers: keyboard (KBSR/KBDR), display (DSR/DDR) and MCR.
// Accessed by a single-cycle read/write strobe from the controller; read data is combinational.
module lc3_mmio_regs
   import lc3_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_i,
   input  logic        wr_i,
   input  logic [15:0] addr_i,
   input  logic [15:0] wdata_i,
   output logic [15:0] rdata_o,
   input  logic        kb_valid_i,
   input  logic [7:0]  kb_data_i,
   output logic        kb_ready_o,
   output logic        disp_valid_o,
   output logic [7:0]  disp_data_o,
   input  logic        disp_ready_i,
   output logic        halt_o
);

   logic        kb_full_q,   kb_full_d;
   logic [7:0]  kbdr_q,      kbdr_d;
   logic        disp_busy_q, disp_busy_d;
   logic [15:0] ddr_q,       ddr_d;
   logic [15:0] mcr_q,       mcr_d;

   logic kb_take;
   logic kbdr_rd;
   logic ddr_wr;

   assign kb_ready_o   = !kb_full_q;
   assign disp_valid_o = disp_busy_q;
   assign disp_data_o  = ddr_q[7:0];
   assign halt_o       = !mcr_q[15];

   assign kb_take = kb_valid_i && !kb_full_q;
   assign kbdr_rd = rd_i && (addr_i == KBDR_ADDR);
   assign ddr_wr  = wr_i && (addr_i == DDR_ADDR);

   // Next-state for the device registers; busy/full flags are judged on their pre-edge value.
   always_comb begin
      kb_full_d   = kb_full_q;
      kbdr_d      = kbdr_q;
      disp_busy_d = disp_busy_q;
      ddr_d       = ddr_q;
      mcr_d       = mcr_q;

      // A capture can only happen while empty, so a KBDR read that lands on a full
      // buffer always clears it and the pending character is taken next cycle.
      if (kb_take) begin
         kb_full_d = 1'b1;
         kbdr_d    = kb_data_i;
      end else if (kbdr_rd) begin
         kb_full_d = 1'b0;
      end

      // A DDR write while busy is dropped even if the display drains on the same edge.
      if (ddr_wr && !disp_busy_q) begin
         ddr_d       = wdata_i;
         disp_busy_d = 1'b1;
      end else if (disp_busy_q && disp_ready_i) begin
         disp_busy_d = 1'b0;
      end

      if (wr_i && (addr_i == MCR_ADDR)) begin
         mcr_d = wdata_i;
      end
   end

   // Device register state.
   always_ff @(posedge clk) begin
      if (rst) begin
         kb_full_q   <= 1'b0;
         kbdr_q      <= 8'h00;
         disp_busy_q <= 1'b0;
         ddr_q       <= 16'h0000;
         mcr_q       <= MCR_RESET;
      end else begin
         kb_full_q   <= kb_full_d;
         kbdr_q      <= kbdr_d;
         disp_busy_q <= disp_busy_d;
         ddr_q       <= ddr_d;
         mcr_q       <= mcr_d;
      end
   end

   // Read mux over the register map.
   always_comb begin
      rdata_o = 16'h0000;
      case (addr_i)
         KBSR_ADDR: rdata_o = {kb_full_q, 15'b0};
         KBDR_ADDR: rdata_o = {8'h00, kbdr_q};
         DSR_ADDR:  rdata_o = {!disp_busy_q, 15'b0};
         DDR_ADDR:  rdata_o = ddr_q;
         MCR_ADDR:  rdata_o = mcr_q;
         default:   rdata_o = 16'h0000;
      endcase
   end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory access controller: one load/store at a time, device registers served
// internally, everything else forwarded to the registered single-port RAM.
//
//  state | meaning
//  IDLE  | waiting for mem_req; device accesses complete here in one edge
//  ISSUE | ram_cs asserted for exactly one cycle with latched request
//  WAIT  | waiting for ram_ready, down-counting the timeout
//  DONE  | mem_done pulse (mem_err if the RAM timed out)
module lc3_mem_ctrl
   import lc3_mem_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   lc3_mem_ctrl_if.slave mem,
   output logic          ram_cs,
   output logic          ram_r_w,
   output logic [15:0]   ram_addr,
   output logic [15:0]   ram_data_in,
   input  logic          ram_ready,
   input  logic [15:0]   ram_data_out,
   input  logic          kb_valid,
   input  logic [7:0]    kb_data,
   output logic          kb_ready,
   output logic          disp_valid,
   output logic [7:0]    disp_data,
   input  logic          disp_ready,
   output logic          halt
);

   localparam int TW = $clog2(TIMEOUT + 1);

   mem_state_e  state_q, state_d;
   logic [15:0] addr_q,  addr_d;
   logic        we_q,    we_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        err_q,   err_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic        dev_rd;
   logic        dev_wr;
   logic [15:0] dev_rdata;

   assign ram_cs      = (state_q == ST_ISSUE);
   assign ram_r_w     = (state_q == ST_ISSUE) && we_q;
   assign ram_addr    = addr_q;
   assign ram_data_in = wdata_q;

   assign mem.mem_done  = (state_q == ST_DONE);
   assign mem.mem_err   = (state_q == ST_DONE) && err_q;
   assign mem.mem_rdata = rdata_q;

   // Device registers see the live request so the access completes on the accepting edge.
   lc3_mmio_regs u_regs (
      .clk          (clk),
      .rst          (rst),
      .rd_i         (dev_rd),
      .wr_i         (dev_wr),
      .addr_i       (mem.mem_addr),
      .wdata_i      (mem.mem_wdata),
      .rdata_o      (dev_rdata),
      .kb_valid_i   (kb_valid),
      .kb_data_i    (kb_data),
      .kb_ready_o   (kb_ready),
      .disp_valid_o (disp_valid),
      .disp_data_o  (disp_data),
      .disp_ready_i (disp_ready),
      .halt_o       (halt)
   );

   // Next-state, request latching, timeout countdown and device strobes.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      dev_rd  = 1'b0;
      dev_wr  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem.mem_req) begin
               addr_d  = mem.mem_addr;
               we_d    = mem.mem_we;
               wdata_d = mem.mem_wdata;
               err_d   = 1'b0;
               if (is_mmio(mem.mem_addr)) begin
                  dev_wr = mem.mem_we;
                  dev_rd = !mem.mem_we;
                  if (!mem.mem_we) begin
                     rdata_d = dev_rdata;
                  end
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            tmo_d   = TW'(TIMEOUT - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (ram_ready) begin
               if (!we_q) begin
                  rdata_d = ram_data_out;
               end
               state_d = ST_DONE;
            end else if (tmo_q == '0) begin
               err_d   = 1'b1;
               rdata_d = 16'h0000;
               state_d = ST_DONE;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= 16'h0000;
         we_q    <= 1'b0;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl with a small registered RAM model.
module tb_lc3_mem_ctrl;
   import lc3_mem_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lc3_mem_ctrl_if mem_bus ();

   logic        ram_cs, ram_r_w, ram_ready;
   logic [15:0] ram_addr, ram_data_in, ram_data_out;
   logic        kb_valid, kb_ready, disp_valid, disp_ready, halt;
   logic [7:0]  kb_data, disp_data;

   lc3_mem_ctrl #(.TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem          (mem_bus),
      .ram_cs       (ram_cs),
      .ram_r_w      (ram_r_w),
      .ram_addr     (ram_addr),
      .ram_data_in  (ram_data_in),
      .ram_ready    (ram_ready),
      .ram_data_out (ram_data_out),
      .kb_valid     (kb_valid),
      .kb_data      (kb_data),
      .kb_ready     (kb_ready),
      .disp_valid   (disp_valid),
      .disp_data    (disp_data),
      .disp_ready   (disp_ready),
      .halt         (halt)
   );

   // Single-cycle registered RAM; ram_stall forces ram_ready low.
   logic [15:0] ram_mem [0:255];
   logic        ram_rdy_q = 1'b0;
   logic        ram_stall;
   assign ram_ready = ram_rdy_q && !ram_stall;

   always @(posedge clk) begin
      ram_rdy_q <= ram_cs;
      if (ram_cs) begin
         if (ram_r_w) ram_mem[ram_addr[7:0]] <= ram_data_in;
         else         ram_data_out <= ram_mem[ram_addr[7:0]];
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One request; cyc = edges from acceptance window until mem_done is seen.
   task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         output logic [15:0] rdata, output logic err,
                         output int cyc, output int cs_cnt);
      @(negedge clk);
      mem_bus.mem_req   = 1'b1;
      mem_bus.mem_we    = we;
      mem_bus.mem_addr  = addr;
      mem_bus.mem_wdata = wdata;
      cyc    = 0;
      cs_cnt = 0;
      while (cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (ram_cs) cs_cnt++;
         if (mem_bus.mem_done) break;
      end
      rdata = mem_bus.mem_rdata;
      err   = mem_bus.mem_err;
      mem_bus.mem_req = 1'b0;
   endtask

   logic [15:0] rd;
   logic        er;
   int          cy, cs;
   int          done_cnt;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      mem_bus.mem_req = 1'b0; mem_bus.mem_we = 1'b0;
      mem_bus.mem_addr = 16'h0; mem_bus.mem_wdata = 16'h0;
      kb_valid = 1'b0; kb_data = 8'h00; disp_ready = 1'b0; ram_stall = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ram_cs",    ram_cs, 0);
      chk("rst_ram_addr",  ram_addr, 0);
      chk("rst_mem_done",  mem_bus.mem_done, 0);
      chk("rst_mem_rdata", mem_bus.mem_rdata, 0);
      chk("rst_kb_ready",  kb_ready, 1);
      chk("rst_disp_valid", disp_valid, 0);
      chk("rst_halt",      halt, 0);
      rst = 1'b0;

      // RAM store / load
      access(1'b1, 16'h3000, 16'hBEEF, rd, er, cy, cs);
      chk("st_cycles", cy, 3);
      chk("st_cs_cnt", cs, 1);
      chk("st_err", er, 0);
      access(1'b1, 16'h3001, 16'h1234, rd, er, cy, cs);
      access(1'b0, 16'h3000, 16'h0000, rd, er, cy, cs);
      chk("ld_data", rd, 16'hBEEF);
      chk("ld_cycles", cy, 3);
      chk("ld_cs_cnt", cs, 1);
      access(1'b0, 16'h3001, 16'h0000, rd, er, cy, cs);
      chk("ld2_data", rd, 16'h1234);

      // Keyboard
      @(negedge clk);
      kb_valid = 1'b1; kb_data = 8'h41;
      @(negedge clk);
      kb_valid = 1'b0;
      chk("kb_ready_full", kb_ready, 0);
      access(1'b0, KBSR_ADDR, 16'h0, rd, er, cy, cs);
      chk("kbsr_full", rd, 16'h8000);
      chk("dev_cycles", cy, 1);
      chk("dev_cs_cnt", cs, 0);
      access(1'b0, KBDR_ADDR, 16'h0, rd, er, cy, cs);
      chk("kbdr_data", rd, 16'h0041);
      access(1'b0, KBSR_ADDR, 16'h0, rd, er, cy, cs);
      chk("kbsr_empty", rd, 16'h0000);
      // Character offered while the buffer is still full: taken only after the KBDR read.
      @(negedge clk);
      kb_valid = 1'b1; kb_data = 8'h42;
      @(negedge clk);
      kb_data = 8'h43;
      access(1'b0, KBDR_ADDR, 16'h0, rd, er, cy, cs);
      chk("kbdr_data2", rd, 16'h0042);
      chk("kb_ready_cleared", kb_ready, 1);
      @(negedge clk);
      kb_valid = 1'b0;
      chk("kb_ready_refill", kb_ready, 0);
      access(1'b0, KBDR_ADDR, 16'h0, rd, er, cy, cs);
      chk("kbdr_data3", rd, 16'h0043);

      // Display
      access(1'b1, DDR_ADDR, 16'h0048, rd, er, cy, cs);
      chk("disp_valid", disp_valid, 1);
      chk("disp_data", disp_data, 8'h48);
      access(1'b0, DSR_ADDR, 16'h0, rd, er, cy, cs);
      chk("dsr_busy", rd, 16'h0000);
      access(1'b1, DDR_ADDR, 16'h0055, rd, er, cy, cs);
      access(1'b0, DDR_ADDR, 16'h0, rd, er, cy, cs);
      chk("ddr_dropped", rd, 16'h0048);
      chk("disp_data_kept", disp_data, 8'h48);
      disp_ready = 1'b1;
      @(negedge clk);
      disp_ready = 1'b0;
      chk("disp_valid_drained", disp_valid, 0);
      access(1'b0, DSR_ADDR, 16'h0, rd, er, cy, cs);
      chk("dsr_ready", rd, 16'h8000);

      // Halt via MCR
      access(1'b1, MCR_ADDR, 16'h0000, rd, er, cy, cs);
      chk("halt_set", halt, 1);
      access(1'b0, MCR_ADDR, 16'h0, rd, er, cy, cs);
      chk("mcr_read", rd, 16'h0000);

      // Timeout: make mem_rdata nonzero first so the zeroing is visible.
      access(1'b0, DSR_ADDR, 16'h0, rd, er, cy, cs);
      ram_stall = 1'b1;
      access(1'b0, 16'h4000, 16'h0, rd, er, cy, cs);
      chk("tmo_cycles", cy, 18);
      chk("tmo_err", er, 1);
      chk("tmo_rdata", rd, 16'h0000);
      chk("tmo_cs_cnt", cs, 1);

      // Reset during WAIT
      @(negedge clk);
      mem_bus.mem_req = 1'b1; mem_bus.mem_we = 1'b0; mem_bus.mem_addr = 16'h4000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_wait", (dut.state_q == ST_WAIT), 1);
      rst = 1'b1;
      mem_bus.mem_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_wait_idle", (dut.state_q == ST_IDLE), 1);
      chk("rst_wait_cs", ram_cs, 0);
      chk("rst_wait_done", mem_bus.mem_done, 0);
      chk("rst_wait_halt", halt, 0);
      rst = 1'b0;
      ram_stall = 1'b0;
      done_cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (mem_bus.mem_done) done_cnt++;
      end
      chk("rst_no_done", done_cnt, 0);
      access(1'b0, MCR_ADDR, 16'h0, rd, er, cy, cs);
      chk("rst_mcr", rd, 16'h8000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
